// File: rtl/fifo_break_dv.sv
// Elastic FIFO with registered valid and ready paths.
// No combinational path exists between the input and output handshakes.
module fifo_break_dv #(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef logic [PW-1:0] ptr_t;

    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic wr, rd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic ptr_t nxt(input ptr_t p);
        if (p == ptr_t'(NUM_SLOTS - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    assign ins_ready  = ~full_q;
    assign outs_valid = ~empty_q;
    assign outs       = mem_q[head_q];

    always_comb begin
        wr      = ins_valid & ~full_q;
        rd      = ~empty_q & outs_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (wr) begin
            tail_d = nxt(tail_q);
        end
        if (rd) begin
            head_d = nxt(head_q);
        end
        if (wr && !rd) begin
            empty_d = 1'b0;
            full_d  = (nxt(tail_q) == head_q);
        end else if (rd && !wr) begin
            full_d  = 1'b0;
            empty_d = (nxt(head_q) == tail_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage carries no reset; only the flags say what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem_q[tail_q] <= ins;
        end
    end

endmodule

// File: tb/tb_fifo_break_dv.sv
// Bench for fifo_break_dv at depths 4, 3 and 1.
// Expectations come from a per-instance token-queue model.
module tb_fifo_break_dv;

    localparam int NI = 3;

    int cap [NI] = '{4, 3, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]      r;
    logic [NI-1:0]      vi;
    logic [NI-1:0]      ro;
    logic [NI-1:0]      ir;
    logic [NI-1:0]      vo;
    logic [NI-1:0][7:0] di;
    logic [NI-1:0][7:0] dout;

    logic [7:0] mq [NI][$];

    int n_cmp = 0;
    int n_err = 0;

    fifo_break_dv #(.NUM_SLOTS(4), .DATA_TYPE(8)) u4 (
        .clk(clk), .rst(r[0]), .ins(di[0]), .ins_valid(vi[0]),
        .ins_ready(ir[0]), .outs(dout[0]), .outs_valid(vo[0]),
        .outs_ready(ro[0])
    );
    fifo_break_dv #(.NUM_SLOTS(3), .DATA_TYPE(8)) u3 (
        .clk(clk), .rst(r[1]), .ins(di[1]), .ins_valid(vi[1]),
        .ins_ready(ir[1]), .outs(dout[1]), .outs_valid(vo[1]),
        .outs_ready(ro[1])
    );
    fifo_break_dv #(.NUM_SLOTS(1), .DATA_TYPE(8)) u1 (
        .clk(clk), .rst(r[2]), .ins(di[2]), .ins_valid(vi[2]),
        .ins_ready(ir[2]), .outs(dout[2]), .outs_valid(vo[2]),
        .outs_ready(ro[2])
    );

    // Advance the token model with the current inputs, then one clock.
    task automatic tick();
        bit dr, dw;
        for (int k = 0; k < NI; k++) begin
            if (r[k]) begin
                mq[k].delete();
            end else begin
                dr = (mq[k].size() > 0) && ro[k];
                dw = (mq[k].size() < cap[k]) && vi[k];
                if (dr) void'(mq[k].pop_front());
                if (dw) mq[k].push_back(di[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r  = '0;
        vi = '0;
        ro = '0;
        di = '0;
    endtask

    task automatic rst_inst(input int k);
        idle();
        r[k] = 1'b1;
        tick();
        r[k] = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        r = '1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (ir[0] !== 1'b1 || vo[0] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flags: ready=%b valid=%b want 1/0",
                         ir[0], vo[0]);
            end
        end
        r = '0;
        di[0] = 8'hA5;
        vi[0] = 1'b1;
        ro[0] = 1'b1;
        tick();
        vi[0] = 1'b0;
        n_cmp++;
        if (vo[0] !== 1'b1 || dout[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL single_tok: valid=%b data=%h want 1/a5",
                     vo[0], dout[0]);
        end
        tick();
        n_cmp++;
        if (vo[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: valid=%b want 0", vo[0]);
        end
    endtask

    task automatic test_fill();
        int val, acc;
        logic [7:0] got [$];
        rst_inst(0);
        val = 1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            di[0] = 8'(val);
            vi[0] = (val <= 6);
            if (vi[0] && ir[0]) begin
                acc++;
                val++;
            end
            tick();
            if (acc > 0) begin
                n_cmp++;
                if (vo[0] !== 1'b1 || dout[0] !== 8'h01) begin
                    n_err++;
                    $display("FAIL fill_head: valid=%b data=%h want 1/01",
                             vo[0], dout[0]);
                end
            end
        end
        n_cmp++;
        if (acc != 4 || ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fill_count: accepted=%0d ready=%b want 4/0",
                     acc, ir[0]);
        end
        ro[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            di[0] = 8'(val);
            vi[0] = (val <= 6);
            if (vo[0]) got.push_back(dout[0]);
            if (vi[0] && ir[0]) val++;
            tick();
        end
        idle();
        n_cmp++;
        if (got.size() != 6) begin
            n_err++;
            $display("FAIL fill_drain_n: got %0d tokens want 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_cmp++;
            if (got[i] !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL fill_order[%0d]: got %h want %h",
                         i, got[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_stream();
        int val, nout;
        rst_inst(1);
        ro[1] = 1'b1;
        val = 0;
        nout = 0;
        for (int c = 0; c < 24; c++) begin
            vi[1] = (val < 20);
            di[1] = 8'(val);
            if (vo[1]) begin
                n_cmp++;
                if (dout[1] !== 8'(nout) || c != nout + 1) begin
                    n_err++;
                    $display("FAIL stream[%0d]: data=%h cyc=%0d want %h/%0d",
                             nout, dout[1], c, 8'(nout), nout + 1);
                end
                nout++;
            end
            n_cmp++;
            if (ir[1] !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready: cyc=%0d ready=%b want 1",
                         c, ir[1]);
            end
            if (vi[1] && ir[1]) val++;
            tick();
        end
        idle();
        n_cmp++;
        if (nout != 20) begin
            n_err++;
            $display("FAIL stream_count: got %0d want 20", nout);
        end
    endtask

    task automatic test_back_to_back();
        rst_inst(0);
        for (int i = 0; i < 4; i++) begin
            di[0] = 8'h10 + 8'(i);
            vi[0] = 1'b1;
            tick();
        end
        vi[0] = 1'b1;
        ro[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            di[0] = 8'h20 + 8'(i);
            n_cmp++;
            if (ir[0] !== (mq[0].size() < 4) || vo[0] !== 1'b1 ||
                dout[0] !== mq[0][0]) begin
                n_err++;
                $display("FAIL b2b[%0d]: rdy=%b vld=%b d=%h want %b/1/%h",
                         i, ir[0], vo[0], dout[0],
                         mq[0].size() < 4, mq[0][0]);
            end
            if (i < 2) begin
                n_cmp++;
                if (ir[0] !== (i == 1)) begin
                    n_err++;
                    $display("FAIL b2b_ready[%0d]: got %b want %b",
                             i, ir[0], i == 1);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_single_slot();
        int val, nout;
        rst_inst(2);
        vi[2] = 1'b1;
        ro[2] = 1'b1;
        val = 0;
        nout = 0;
        for (int c = 0; c < 12; c++) begin
            di[2] = 8'(val);
            n_cmp++;
            if (vo[2] !== (c % 2 == 1)) begin
                n_err++;
                $display("FAIL one_valid[%0d]: got %b want %b",
                         c, vo[2], c % 2 == 1);
            end
            if (vo[2]) begin
                n_cmp++;
                if (dout[2] !== 8'(nout)) begin
                    n_err++;
                    $display("FAIL one_data[%0d]: got %h want %h",
                             nout, dout[2], 8'(nout));
                end
                nout++;
            end
            if (ir[2]) val++;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        rst_inst(0);
        for (int i = 0; i < 3; i++) begin
            di[0] = 8'h30 + 8'(i);
            vi[0] = 1'b1;
            tick();
        end
        di[0] = 8'h55;
        ro[0] = 1'b1;
        r[0]  = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (vo[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_flags: valid=%b ready=%b want 0/1",
                     vo[0], ir[0]);
        end
        di[0] = 8'h77;
        vi[0] = 1'b1;
        tick();
        vi[0] = 1'b0;
        n_cmp++;
        if (vo[0] !== 1'b1 || dout[0] !== 8'h77) begin
            n_err++;
            $display("FAIL midrst_tok: valid=%b data=%h want 1/77",
                     vo[0], dout[0]);
        end
        ro[0] = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (vo[k] !== (mq[k].size() > 0) ||
                    ir[k] !== (mq[k].size() < cap[k])) begin
                    n_err++;
                    $display("FAIL rnd_flags[%0d] c=%0d: v=%b r=%b want %b/%b",
                             k, c, vo[k], ir[k],
                             mq[k].size() > 0, mq[k].size() < cap[k]);
                end
                if (mq[k].size() > 0) begin
                    n_cmp++;
                    if (dout[k] !== mq[k][0]) begin
                        n_err++;
                        $display("FAIL rnd_data[%0d] c=%0d: got %h want %h",
                                 k, c, dout[k], mq[k][0]);
                    end
                end
                vi[k] = ($urandom_range(3, 0) != 0);
                ro[k] = ($urandom_range(3, 0) != 0);
                di[k] = 8'($urandom);
                r[k]  = ($urandom_range(63, 0) == 0);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        r = '1;
        tick();
        tick();
        idle();
        test_reset();
        test_fill();
        test_stream();
        test_back_to_back();
        test_single_slot();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_break_dv.md
# fifo_break_dv

Parameterised synchronous elastic FIFO that buffers one data channel and registers both the valid and the ready paths, so that no combinational path exists between its input and output handshakes. It sits directly upstream of the lazy fork stage. It decouples a producer from the fork's ready path, which is an AND of all consumer readies. It also absorbs consumer back-pressure jitter of up to `NUM_SLOTS` tokens.

## Interface
- `NUM_SLOTS`, default 4: buffer depth in tokens. Legal values are ≥ 1; non-powers of two are supported.
- `DATA_TYPE`, default 32: token data width in bits. Must be ≥ 1.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ins` input `DATA_TYPE`: input token data.
- `ins_valid` input 1: producer offers a token.
- `ins_ready` output 1: FIFO accepts a token. Driven from registered state only.
- `outs` output `DATA_TYPE`: token at the FIFO head.
- `outs_valid` output 1: head token present. Driven from registered state only.
- `outs_ready` input 1: consumer accepts the head token.

## Operation
- **Storage:** `NUM_SLOTS` × `DATA_TYPE` register array. The array is not reset.
- **Pointers:** `head` (read) and `tail` (write), each `max(1, clog2(NUM_SLOTS))` bits.
  - Each pointer increments by 1 and wraps from `NUM_SLOTS-1` to 0. Wrap is explicit; power-of-two overflow is not relied on.
- **Flags:** registered `full` and `empty`.
- **Handshake signals:**
  - `ins_ready = !full`
  - `outs_valid = !empty`
  - `outs = mem[head]`
- **Events:**
  - `wr = ins_valid & ins_ready`
  - `rd = outs_valid & outs_ready`
- **On `wr`:** `mem[tail] <= ins`, then `tail` advances.
- **On `rd`:** `head` advances.
- **Flag updates:**
  - `wr & !rd`: `empty <= 0`; `full <= 1` if the next `tail` equals `head`.
  - `rd & !wr`: `full <= 0`; `empty <= 1` if the next `head` equals `tail`.
  - `wr & rd`: both flags hold. Occupancy is unchanged and both pointers advance.
- **States:**
  - EMPTY (`empty=1`): only `wr` is possible.
  - PARTIAL: `wr`, `rd`, or both are possible.
  - FULL (`full=1`): only `rd` is possible. An offered token waits; `ins_ready` rises in the cycle after the `rd`.
- **Invariants:**
  - `full & empty` is never 1.
  - Tokens leave in arrival order, with no loss and no duplication.
- **Data-on-invalid:** the value of `outs` while `outs_valid=0` is don't-care and must not be checked.
- **`NUM_SLOTS=1`:** the block degenerates to a one-slot dv-breaking buffer.
  - Throughput is at most 1 token per 2 cycles, because there is no ready bypass.
  - This is accepted behaviour, not a bug.

## Timing
- **Reset** (`rst=1` sampled at a rising edge), effective on that edge:
  - `head=0`, `tail=0`, `empty=1`, `full=0`
  - therefore `outs_valid=0` and `ins_ready=1` from the following cycle.
- **Reset mid-operation:** all buffered tokens are discarded. A `wr` or `rd` handshake in the reset cycle has no effect on state.
- **Latency:** a token written at edge N appears on `outs` with `outs_valid=1` in cycle N+1.
  - The FIFO has no combinational data bypass, even when empty.
- **Throughput:**
  - 1 token/cycle for `NUM_SLOTS ≥ 2`, with a continuous producer and consumer.
  - 1 token/2 cycles for `NUM_SLOTS = 1`.
- **No combinational paths:**
  - `ins_ready` does not depend on `outs_ready`.
  - `outs_valid` and `outs` do not depend on `ins_valid` or `ins`.
- **Input stability:** `ins_valid` may be deasserted without a handshake; the FIFO does not require it to be held.
- **Output stability:** once `outs_valid=1`, `outs_valid` and `outs` stay stable until `rd` occurs.

## Test plan
- **Reset and single token:** assert `rst` for 2 cycles, then send `ins=0xA5` for one cycle with `outs_ready=1`.
  - During reset: `ins_ready=1`, `outs_valid=0`.
  - `outs_valid=1` and `outs=0xA5` exactly one cycle after the write; `outs_valid=0` in the following cycle.
- **Fill to full** (`NUM_SLOTS=4`): with `outs_ready=0`, offer 0x1–0x6.
  - Exactly 4 tokens are accepted; `ins_ready=0` after the 4th write.
  - `outs` holds 0x1 stable.
  - Raising `outs_ready` drains 0x1, 0x2, 0x3, 0x4, then 0x5 and 0x6, in order.
- **Streaming and wrap:** continuous valid/ready for 20 tokens (0–19) with `NUM_SLOTS=3`.
  - One token is accepted and emitted per cycle after the initial 1-cycle latency.
  - Pointers wrap 2→0 repeatedly; the output sequence is 0–19.
- **Simultaneous read/write at full:** fill a 4-slot FIFO, then hold `ins_valid=1` and `outs_ready=1`.
  - In the `rd` cycle `ins_ready=0`, so no write occurs.
  - The next cycle accepts a token, and occupancy alternates between 3 and 4.
- **`NUM_SLOTS=1`:** continuous producer and consumer.
  - `outs_valid` toggles 0,1,0,1…, giving 1 token per 2 cycles, with order preserved.
- **Reset mid-stream:** with 3 tokens buffered, pulse `rst` for 1 cycle.
  - `outs_valid=0` and `ins_ready=1` in the next cycle.
  - The next written token 0x77 is the next token output.
